switch_debouncer: RTL and testbench

Front-end conditioning stage for the lab's slide-switch inputs. It synchronises each raw, bouncing `SW` bit into the `clk` domain and filters it to a clean level. It also generates single-cycle rise and fall strobes. Its `sw_clean` outputs drive the data and clock pins of the downstream gated latch and edge-triggered flip-flops, so those elements see exactly one transition per physical switch flip.

---
 rtl/switch_debouncer.sv | 55 +++++
 tb/tb_switch_debouncer.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/switch_debouncer.sv
// Per-channel switch conditioner: 2-flop synchroniser, stability counter, registered clean level and edge strobes.
// Latency STABLE_CYCLES+2 edges from raw input change to sw_clean/strobe; no backpressure (free-running).
module switch_debouncer #(
  parameter int WIDTH         = 2,
  parameter int STABLE_CYCLES = 50000,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] sw_in,
  output logic [WIDTH-1:0] sw_clean,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic [WIDTH-1:0] busy
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    logic             s1;
    logic             s2;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        s1          <= 1'b0;
        s2          <= 1'b0;
        cnt         <= '0;
        sw_clean[i] <= 1'b0;
        rise[i]     <= 1'b0;
        fall[i]     <= 1'b0;
      end else begin
        s1      <= sw_in[i];
        s2      <= s1;
        rise[i] <= 1'b0;
        fall[i] <= 1'b0;
        if (s2 == sw_clean[i]) begin
          // any bounce back to the clean level restarts qualification
          cnt <= '0;
        end else if (cnt == LAST) begin
          sw_clean[i] <= s2;
          cnt         <= '0;
          rise[i]     <= s2;
          fall[i]     <= ~s2;
        end else begin
          cnt <= cnt + ONE;
        end
      end
    end

    assign busy[i] = (cnt != '0);
  end

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed table-driven bench for switch_debouncer with WIDTH=2, STABLE_CYCLES=4 (6-edge accept latency).
module tb_switch_debouncer;

  logic       clk;
  logic       resetn;
  logic [1:0] sw_in;
  logic [1:0] sw_clean;
  logic [1:0] rise;
  logic [1:0] fall;
  logic [1:0] busy;

  switch_debouncer #(.WIDTH(2), .STABLE_CYCLES(4), .CNT_W(16)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .sw_in    (sw_in),
    .sw_clean (sw_clean),
    .rise     (rise),
    .fall     (fall),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One record per clock: inputs driven before the edge, outputs expected just after it.
  typedef struct {
    logic       rn;
    logic [1:0] sw;
    logic [1:0] clean;
    logic [1:0] rise;
    logic [1:0] fall;
    logic [1:0] busy;
    logic       mid_rst;
  } vec_t;

  vec_t tbl[$];
  int   vectors;
  int   miscompares;

  task automatic add(input logic rn, input logic [1:0] sw, input logic [1:0] cl,
                     input logic [1:0] r, input logic [1:0] f, input logic [1:0] b);
    vec_t v;
    v.rn = rn; v.sw = sw; v.clean = cl; v.rise = r; v.fall = f; v.busy = b; v.mid_rst = 1'b0;
    tbl.push_back(v);
  endtask

  // Input steps to sw from a settled state: 2 synchroniser edges, 3 counting edges, accept, one settled cycle.
  task automatic qualify(input logic [1:0] sw, input logic [1:0] from_cl, input logic [1:0] to_cl,
                         input logic [1:0] b, input logic [1:0] r, input logic [1:0] f);
    for (int i = 0; i < 2; i++) add(1'b1, sw, from_cl, 2'b00, 2'b00, 2'b00);
    for (int i = 0; i < 3; i++) add(1'b1, sw, from_cl, 2'b00, 2'b00, b);
    add(1'b1, sw, to_cl, r, f, 2'b00);
    add(1'b1, sw, to_cl, 2'b00, 2'b00, 2'b00);
  endtask

  task automatic reset_to_zero();
    add(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    add(1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    add(1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
  endtask

  task automatic check(input string name, input int idx, input logic [7:0] exp);
    logic [7:0] got;
    got = {sw_clean, rise, fall, busy};
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s #%0d clean/rise/fall/busy got %b/%b/%b/%b want %b/%b/%b/%b", name, idx,
               got[7:6], got[5:4], got[3:2], got[1:0], exp[7:6], exp[5:4], exp[3:2], exp[1:0]);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;

    // Reset held with both switches high, then release: single rise on both channels
    for (int i = 0; i < 10; i++) add(1'b0, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00);
    qualify(2'b11, 2'b00, 2'b11, 2'b11, 2'b11, 2'b00);
    reset_to_zero();

    // Clean rise then fall on channel 0
    qualify(2'b01, 2'b00, 2'b01, 2'b01, 2'b01, 2'b00);
    add(1'b1, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00);
    qualify(2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b01);

    // Pulse of STABLE_CYCLES-1 at the input: rejected, busy clears
    for (int i = 0; i < 2; i++) add(1'b1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
    add(1'b1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01);
    add(1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01);
    add(1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01);
    add(1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    add(1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);

    // Pulse of exactly STABLE_CYCLES: accepted, then the return to 0 is accepted too
    for (int i = 0; i < 2; i++) add(1'b1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
    for (int i = 0; i < 2; i++) add(1'b1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01);
    add(1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01);
    add(1'b1, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00);
    for (int i = 0; i < 3; i++) add(1'b1, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01);
    add(1'b1, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00);
    add(1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);

    // Bounce: toggle every 2 cycles for 12 cycles, then hold high
    for (int i = 0; i < 12; i++)
      add(1'b1, (i % 4 < 2) ? 2'b01 : 2'b00, 2'b00, 2'b00, 2'b00, (i % 4 >= 2) ? 2'b01 : 2'b00);
    qualify(2'b01, 2'b00, 2'b01, 2'b01, 2'b01, 2'b00);
    reset_to_zero();

    // Concurrent channels
    qualify(2'b11, 2'b00, 2'b11, 2'b11, 2'b11, 2'b00);
    add(1'b1, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00);
    qualify(2'b01, 2'b11, 2'b01, 2'b10, 2'b00, 2'b10);
    reset_to_zero();

    // Mid-count reset: count channel 0 up to 2, drop resetn between edges, release with switch high
    for (int i = 0; i < 2; i++) add(1'b1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
    add(1'b1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01);
    add(1'b1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01);
    tbl[tbl.size()-1].mid_rst = 1'b1;
    for (int i = 0; i < 2; i++) add(1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
    qualify(2'b01, 2'b00, 2'b01, 2'b01, 2'b01, 2'b00);

    // Reset state before any clock edge
    resetn = 1'b0;
    sw_in  = 2'b11;
    #1;
    check("reset_state", 0, 8'h00);
    @(negedge clk);

    for (int i = 0; i < tbl.size(); i++) begin
      resetn = tbl[i].rn;
      sw_in  = tbl[i].sw;
      @(posedge clk);
      #1;
      check("vec", i, {tbl[i].clean, tbl[i].rise, tbl[i].fall, tbl[i].busy});
      if (tbl[i].mid_rst) begin
        #3;
        resetn = 1'b0;
        #1;
        check("async_reset", i, 8'h00);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
